// File: rtl/vend_pkg.sv
// Shared types and constants for the vending scheduler: FSM states, coin codes,
// change-coin value and default prices.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPENSE = 2'd1,
        ST_CHANGE   = 2'd2
    } vend_state_e;

    localparam logic [1:0] COIN_5  = 2'b01;
    localparam logic [1:0] COIN_10 = 2'b10;

    localparam int CREDIT_W        = 6;
    localparam int CHG_COIN        = 5;

    localparam int DEF_PRICE0      = 15;
    localparam int DEF_PRICE1      = 20;
    localparam int DEF_PRICE2      = 25;
    localparam int DEF_PRICE3      = 10;
    localparam int DEF_MAX_CREDIT  = 30;
    localparam int DEF_TIMEOUT_CYC = 16;

    function automatic logic [CREDIT_W:0] coin_amount(input logic [1:0] code);
        case (code)
            COIN_5:  coin_amount = 7'd5;
            COIN_10: coin_amount = 7'd10;
            default: coin_amount = 7'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_timeout_cnt.sv
// Dispense-ack watchdog: down-counter reloaded by clr, expired at terminal count.
// Only compiled when VEND_TIMEOUT_EN is defined.
`ifdef VEND_TIMEOUT_EN
module vend_timeout_cnt #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam int W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [W-1:0] cnt;

    // Loaded with TIMEOUT_CYC-1 so expiry lands on the TIMEOUT_CYC-th enabled cycle.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= W'(TIMEOUT_CYC - 1);
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expired = en && (cnt == '0);

endmodule
`endif

// File: rtl/vend_sched.sv
// Vending-machine credit/dispense/change scheduler.
// Optional dispense-ack timeout enabled by macro VEND_TIMEOUT_EN.
//
// state       | meaning
// ST_IDLE     | accepting coins, selections and cancel
// ST_DISPENSE | disp_req held until disp_ack (or timeout)
// ST_CHANGE   | chg_req held, one 5-rupee coin per chg_ack until credit is 0
module vend_sched
    import vend_pkg::*;
#(
    parameter int PRICE0      = DEF_PRICE0,
    parameter int PRICE1      = DEF_PRICE1,
    parameter int PRICE2      = DEF_PRICE2,
    parameter int PRICE3      = DEF_PRICE3,
    parameter int MAX_CREDIT  = DEF_MAX_CREDIT,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [1:0]          coin_val,
    input  logic                sel_valid,
    input  logic [1:0]          sel_id,
    input  logic                cancel,
    output logic                disp_req,
    output logic [1:0]          disp_id,
    input  logic                disp_ack,
    output logic                chg_req,
    input  logic                chg_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_rej,
    output logic                sel_nack,
    output logic                fault,
    output logic                busy
);

    vend_state_e         state, state_nxt;
    logic [CREDIT_W-1:0] credit_nxt;
    logic [1:0]          disp_id_nxt;
    logic                coin_rej_nxt, sel_nack_nxt;
    logic                fault_nxt;
    logic [CREDIT_W:0]   coin_amt, credit_plus;
    logic [CREDIT_W-1:0] price_sel, price_disp;
    logic                coin_ok, expired;

    function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] id);
        case (id)
            2'd0:    price_of = CREDIT_W'(PRICE0);
            2'd1:    price_of = CREDIT_W'(PRICE1);
            2'd2:    price_of = CREDIT_W'(PRICE2);
            default: price_of = CREDIT_W'(PRICE3);
        endcase
    endfunction

    assign coin_amt    = coin_amount(coin_val);
    assign coin_ok     = (coin_amt != '0);
    assign credit_plus = {1'b0, credit} + coin_amt;
    assign price_sel   = price_of(sel_id);
    assign price_disp  = price_of(disp_id);

`ifdef VEND_TIMEOUT_EN
    vend_timeout_cnt #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .en      (state == ST_DISPENSE),
        .clr     (state != ST_DISPENSE),
        .expired (expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = TIMEOUT_CYC[0];
    assign expired        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            credit   <= '0;
            disp_id  <= '0;
            coin_rej <= 1'b0;
            sel_nack <= 1'b0;
            fault    <= 1'b0;
        end else begin
            state    <= state_nxt;
            credit   <= credit_nxt;
            disp_id  <= disp_id_nxt;
            coin_rej <= coin_rej_nxt;
            sel_nack <= sel_nack_nxt;
            fault    <= fault_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        credit_nxt   = credit;
        disp_id_nxt  = disp_id;
        coin_rej_nxt = 1'b0;
        sel_nack_nxt = 1'b0;
        fault_nxt    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                // An effective cancel swallows any selection and rejects any coin.
                if (cancel && (credit != '0)) begin
                    state_nxt    = ST_CHANGE;
                    coin_rej_nxt = coin_valid;
                end else if (coin_valid) begin
                    if (coin_ok && (credit_plus <= (CREDIT_W+1)'(MAX_CREDIT))) begin
                        credit_nxt = credit_plus[CREDIT_W-1:0];
                    end else begin
                        coin_rej_nxt = 1'b1;
                    end
                    sel_nack_nxt = sel_valid;
                end else if (sel_valid) begin
                    if (credit >= price_sel) begin
                        credit_nxt  = credit - price_sel;
                        disp_id_nxt = sel_id;
                        state_nxt   = ST_DISPENSE;
                    end else begin
                        sel_nack_nxt = 1'b1;
                    end
                end
            end
            ST_DISPENSE: begin
                coin_rej_nxt = coin_valid;
                if (disp_ack) begin
                    state_nxt = (credit != '0) ? ST_CHANGE : ST_IDLE;
                end else if (expired) begin
                    fault_nxt  = 1'b1;
                    credit_nxt = credit + price_disp;
                    state_nxt  = ST_CHANGE;
                end
            end
            ST_CHANGE: begin
                coin_rej_nxt = coin_valid;
                if (chg_ack) begin
                    credit_nxt = credit - CREDIT_W'(CHG_COIN);
                    if (credit == CREDIT_W'(CHG_COIN)) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign disp_req = (state == ST_DISPENSE);
    assign chg_req  = (state == ST_CHANGE);
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_vend_sched.sv
// Directed vector bench for vend_sched: table of per-cycle stimulus and expected
// outputs, plus hand sequences for long dispense waits and the ack timeout.
module tb_vend_sched;
    import vend_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_val = 2'b00;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_id = 2'b00;
    logic       cancel = 1'b0;
    logic       disp_ack = 1'b0;
    logic       chg_ack = 1'b0;
    logic       disp_req, chg_req, coin_rej, sel_nack, fault, busy;
    logic [1:0] disp_id;
    logic [5:0] credit;

    int n_vec = 0;
    int n_err = 0;

    vend_sched dut (
        .clk        (clk),
        .rst        (rst),
        .coin_valid (coin_valid),
        .coin_val   (coin_val),
        .sel_valid  (sel_valid),
        .sel_id     (sel_id),
        .cancel     (cancel),
        .disp_req   (disp_req),
        .disp_id    (disp_id),
        .disp_ack   (disp_ack),
        .chg_req    (chg_req),
        .chg_ack    (chg_ack),
        .credit     (credit),
        .coin_rej   (coin_rej),
        .sel_nack   (sel_nack),
        .fault      (fault),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r, cv;
        logic [1:0]  cval;
        logic        sv;
        logic [1:0]  sid;
        logic        can, dack, cack;
        logic [13:0] exp;
    } vec_t;

    vec_t tbl[$];

    // {credit, disp_req, disp_id, chg_req, coin_rej, sel_nack, fault, busy}
    function automatic logic [13:0] o(input int cr, input bit dreq, input int did,
                                      input bit creq, input bit rej, input bit nack,
                                      input bit flt, input bit bsy);
        o = {6'(cr), dreq, 2'(did), creq, rej, nack, flt, bsy};
    endfunction

    function automatic vec_t v(input bit r, input bit cv, input logic [1:0] cval,
                               input bit sv, input logic [1:0] sid, input bit can,
                               input bit dack, input bit cack, input logic [13:0] e);
        vec_t t;
        t.r = r; t.cv = cv; t.cval = cval; t.sv = sv; t.sid = sid;
        t.can = can; t.dack = dack; t.cack = cack; t.exp = e;
        return t;
    endfunction

    task automatic step(input vec_t t, input string nm);
        logic [13:0] act;
        rst = t.r; coin_valid = t.cv; coin_val = t.cval; sel_valid = t.sv;
        sel_id = t.sid; cancel = t.can; disp_ack = t.dack; chg_ack = t.cack;
        @(posedge clk);
        #1;
        act = {credit, disp_req, disp_id, chg_req, coin_rej, sel_nack, fault, busy};
        n_vec++;
        if (act !== t.exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b (credit,dreq,did,creq,rej,nack,fault,busy)",
                     nm, act, t.exp);
        end
    endtask

    initial begin
        // reset, reset ignores coin
        tbl.push_back(v(1,0,0,0,0,0,0,0, o( 0,0,0,0,0,0,0,0)));
        tbl.push_back(v(1,1,2,0,0,0,0,0, o( 0,0,0,0,0,0,0,0)));
        // 10+5, sel 0, ack -> idle with no change
        tbl.push_back(v(0,1,2,0,0,0,0,0, o(10,0,0,0,0,0,0,0)));
        tbl.push_back(v(0,1,1,0,0,0,0,0, o(15,0,0,0,0,0,0,0)));
        tbl.push_back(v(0,0,0,1,0,0,0,0, o( 0,1,0,0,0,0,0,1)));
        tbl.push_back(v(0,0,0,0,0,0,0,0, o( 0,1,0,0,0,0,0,1)));
        tbl.push_back(v(0,0,0,0,0,0,1,0, o( 0,0,0,0,0,0,0,0)));
        // 10+10, sel 3, ack -> change, two coins back
        tbl.push_back(v(0,1,2,0,0,0,0,0, o(10,0,0,0,0,0,0,0)));
        tbl.push_back(v(0,1,2,0,0,0,0,0, o(20,0,0,0,0,0,0,0)));
        tbl.push_back(v(0,0,0,1,3,0,0,0, o(10,1,3,0,0,0,0,1)));
        tbl.push_back(v(0,0,0,0,0,0,1,0, o(10,0,3,1,0,0,0,1)));
        tbl.push_back(v(0,0,0,0,0,0,0,0, o(10,0,3,1,0,0,0,1)));
        tbl.push_back(v(0,0,0,0,0,0,0,1, o( 5,0,3,1,0,0,0,1)));
        tbl.push_back(v(0,0,0,0,0,0,0,1, o( 0,0,3,0,0,0,0,0)));
        // credit 25, coin 10 rejected, sel 1, coin rejected in dispense
        tbl.push_back(v(0,1,2,0,0,0,0,0, o(10,0,3,0,0,0,0,0)));
        tbl.push_back(v(0,1,2,0,0,0,0,0, o(20,0,3,0,0,0,0,0)));
        tbl.push_back(v(0,1,1,0,0,0,0,0, o(25,0,3,0,0,0,0,0)));
        tbl.push_back(v(0,1,2,0,0,0,0,0, o(25,0,3,0,1,0,0,0)));
        tbl.push_back(v(0,0,0,0,0,0,0,0, o(25,0,3,0,0,0,0,0)));
        tbl.push_back(v(0,0,0,1,1,0,0,0, o( 5,1,1,0,0,0,0,1)));
        tbl.push_back(v(0,1,1,0,0,0,0,0, o( 5,1,1,0,1,0,0,1)));
        tbl.push_back(v(0,0,0,1,0,0,1,0, o( 5,0,1,1,0,0,0,1)));
        tbl.push_back(v(0,0,0,0,0,0,0,1, o( 0,0,1,0,0,0,0,0)));
        // credit 10, sel 2 nack, cancel -> two change coins
        tbl.push_back(v(0,1,2,0,0,0,0,0, o(10,0,1,0,0,0,0,0)));
        tbl.push_back(v(0,0,0,1,2,0,0,0, o(10,0,1,0,0,1,0,0)));
        tbl.push_back(v(0,0,0,0,0,1,0,0, o(10,0,1,1,0,0,0,1)));
        tbl.push_back(v(0,0,0,0,0,0,0,1, o( 5,0,1,1,0,0,0,1)));
        tbl.push_back(v(0,0,0,0,0,0,0,0, o( 5,0,1,1,0,0,0,1)));
        tbl.push_back(v(0,0,0,0,0,0,0,1, o( 0,0,1,0,0,0,0,0)));
        // coin + sel same cycle
        tbl.push_back(v(0,1,2,0,0,0,0,0, o(10,0,1,0,0,0,0,0)));
        tbl.push_back(v(0,1,1,1,0,0,0,0, o(15,0,1,0,0,1,0,0)));
        tbl.push_back(v(0,0,0,0,0,0,0,0, o(15,0,1,0,0,0,0,0)));
        // invalid codes, cancel overrides coin, cancel ignored in change
        tbl.push_back(v(0,1,0,0,0,0,0,0, o(15,0,1,0,1,0,0,0)));
        tbl.push_back(v(0,1,3,0,0,0,0,0, o(15,0,1,0,1,0,0,0)));
        tbl.push_back(v(0,1,1,0,0,1,0,0, o(15,0,1,1,1,0,0,1)));
        tbl.push_back(v(0,0,0,0,0,1,0,1, o(10,0,1,1,0,0,0,1)));
        tbl.push_back(v(0,0,0,0,0,0,0,1, o( 5,0,1,1,0,0,0,1)));
        tbl.push_back(v(0,0,0,0,0,0,0,1, o( 0,0,1,0,0,0,0,0)));
        // cancel at zero credit ignored, sel at zero credit nacked
        tbl.push_back(v(0,0,0,0,0,1,0,0, o( 0,0,1,0,0,0,0,0)));
        tbl.push_back(v(0,0,0,1,0,0,0,0, o( 0,0,1,0,0,1,0,0)));
        // fill to MAX_CREDIT exactly, one more coin rejected, cancel beats sel
        tbl.push_back(v(0,1,2,0,0,0,0,0, o(10,0,1,0,0,0,0,0)));
        tbl.push_back(v(0,1,2,0,0,0,0,0, o(20,0,1,0,0,0,0,0)));
        tbl.push_back(v(0,1,2,0,0,0,0,0, o(30,0,1,0,0,0,0,0)));
        tbl.push_back(v(0,1,1,0,0,0,0,0, o(30,0,1,0,1,0,0,0)));
        tbl.push_back(v(0,0,0,1,2,1,0,0, o(30,0,1,1,0,0,0,1)));
        // reset mid-change: no refund, stray chg_ack ignored
        tbl.push_back(v(1,0,0,0,0,0,0,1, o( 0,0,0,0,0,0,0,0)));
        tbl.push_back(v(0,0,0,0,0,0,0,1, o( 0,0,0,0,0,0,0,0)));
        // reset mid-dispense with ack pending
        tbl.push_back(v(0,1,2,0,0,0,0,0, o(10,0,0,0,0,0,0,0)));
        tbl.push_back(v(0,1,2,0,0,0,0,0, o(20,0,0,0,0,0,0,0)));
        tbl.push_back(v(0,0,0,1,1,0,0,0, o( 0,1,1,0,0,0,0,1)));
        tbl.push_back(v(1,0,0,0,0,0,1,0, o( 0,0,0,0,0,0,0,0)));
        tbl.push_back(v(0,0,0,0,0,0,1,0, o( 0,0,0,0,0,0,0,0)));

        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

`ifndef VEND_TIMEOUT_EN
        // without the watchdog, dispense waits indefinitely
        step(v(0,1,2,0,0,0,0,0, o(10,0,0,0,0,0,0,0)), "wait_c1");
        step(v(0,1,2,0,0,0,0,0, o(20,0,0,0,0,0,0,0)), "wait_c2");
        step(v(0,1,2,0,0,0,0,0, o(30,0,0,0,0,0,0,0)), "wait_c3");
        step(v(0,0,0,1,2,0,0,0, o( 5,1,2,0,0,0,0,1)), "wait_sel");
        for (int k = 0; k < 20; k++)
            step(v(0,0,0,0,0,0,0,0, o(5,1,2,0,0,0,0,1)), $sformatf("wait_hold%0d", k));
        step(v(0,0,0,0,0,0,1,0, o( 5,0,2,1,0,0,0,1)), "wait_ack");
        step(v(0,0,0,0,0,0,0,1, o( 0,0,2,0,0,0,0,0)), "wait_chg");
`else
        // no ack: fault after TIMEOUT_CYC dispense cycles, price refunded
        step(v(1,0,0,0,0,0,0,0, o( 0,0,0,0,0,0,0,0)), "to_rst");
        step(v(0,1,2,0,0,0,0,0, o(10,0,0,0,0,0,0,0)), "to_c1");
        step(v(0,1,2,0,0,0,0,0, o(20,0,0,0,0,0,0,0)), "to_c2");
        step(v(0,0,0,1,1,0,0,0, o( 0,1,1,0,0,0,0,1)), "to_sel");
        for (int k = 0; k < 15; k++)
            step(v(0,0,0,0,0,0,0,0, o(0,1,1,0,0,0,0,1)), $sformatf("to_hold%0d", k));
        step(v(0,0,0,0,0,0,0,0, o(20,0,1,1,0,0,1,1)), "to_fault");
        step(v(0,0,0,0,0,0,0,0, o(20,0,1,1,0,0,0,1)), "to_after");
        step(v(0,0,0,0,0,0,0,1, o(15,0,1,1,0,0,0,1)), "to_chg1");
        step(v(0,0,0,0,0,0,0,1, o(10,0,1,1,0,0,0,1)), "to_chg2");
        step(v(1,0,0,0,0,0,0,1, o( 0,0,0,0,0,0,0,0)), "to_rstchg");
        step(v(0,0,0,0,0,0,0,0, o( 0,0,0,0,0,0,0,0)), "to_idle");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vend_sched.md
VEND_SCHED -- requirements
Module: vend_sched

Interface
REQ-001 SHALL have parameter PRICE0, default 15, price of product 0 in rupees; multiple of 5, range 5..30.
REQ-002 SHALL have parameter PRICE1, default 20, price of product 1; same constraints.
REQ-003 SHALL have parameter PRICE2, default 25, price of product 2; same constraints.
REQ-004 SHALL have parameter PRICE3, default 10, price of product 3; same constraints.
REQ-005 SHALL have parameter MAX_CREDIT, default 30, credit ceiling in rupees; multiple of 5, at most 63.
REQ-006 SHALL have parameter TIMEOUT_CYC, default 16, dispense-ack timeout in cycles; used only under VEND_TIMEOUT_EN.
REQ-007 SHALL use one clock and a synchronous, active-high reset, with ports as listed in REQ-008 and REQ-009.
REQ-008 clk  in  1  rising-edge clock.
REQ-009 rst  in  1  synchronous active-high reset.
REQ-010 coin_valid  in  1  one-cycle coin strobe.
REQ-011 coin_val  in  2  coin code: 01 = 5, 10 = 10; 00 and 11 are invalid.
REQ-012 sel_valid / sel_id  in  1 / 2  one-cycle product-selection strobe and product index.
REQ-013 cancel  in  1  one-cycle refund request.
REQ-014 disp_req / disp_id  out  1 / 2  dispense request to the vending datapath and the product index.
REQ-015 disp_ack  in  1  datapath completion; valid only while disp_req = 1.
REQ-016 chg_req / chg_ack  out / in  1 / 1  change-coin handshake; each accepted handshake returns one 5-rupee coin.
REQ-017 credit  out  6  current credit in rupees.
REQ-018 coin_rej / sel_nack / fault  out  1 each  one-cycle status pulses.
REQ-019 busy  out  1  high whenever the FSM state is not IDLE.

Function
REQ-020 SHALL implement the FSM states IDLE, DISPENSE and CHANGE.
REQ-021 In IDLE, an accepted valid coin SHALL add its value to credit on the next edge.
- A coin SHALL be rejected when it is invalid, when credit + value > MAX_CREDIT, or when the state is not IDLE.
- A rejected coin SHALL produce a coin_rej pulse one cycle later, and credit SHALL stay unchanged.
REQ-022 In IDLE, sel_valid with credit >= PRICE[sel_id] SHALL perform all of the following on the next edge:
- subtract the price from credit;
- latch disp_id;
- assert disp_req;
- enter DISPENSE.
REQ-023 In IDLE, sel_valid with insufficient credit SHALL pulse sel_nack, and the state SHALL be unchanged.
REQ-024 When coin_valid and sel_valid occur in the same cycle, the coin SHALL be processed and the selection dropped with a sel_nack pulse.
REQ-025 When cancel occurs in IDLE with credit > 0, the FSM SHALL enter CHANGE; cancel with credit = 0 SHALL be ignored.
- cancel SHALL override a coin or selection in the same cycle; a coin presented in that cycle SHALL be rejected.
REQ-026 disp_req and disp_id SHALL be held stable until disp_ack is sampled high.
- On that edge, disp_req SHALL drop.
- The next state SHALL be CHANGE if credit > 0, otherwise IDLE.
REQ-027 In CHANGE, chg_req SHALL be held high.
- Each edge with chg_ack = 1 SHALL decrement credit by 5.
- The edge that brings credit to 0 SHALL clear chg_req and return the FSM to IDLE.
REQ-028 The latency from selection strobe to disp_req SHALL be exactly 1 cycle.
REQ-029 sel_valid and cancel SHALL be ignored outside IDLE.
REQ-030 credit SHALL never exceed MAX_CREDIT and SHALL never go below 0.

Reset
REQ-031 While rst = 1, the block SHALL hold state = IDLE, credit = 0, and every output at 0, including disp_id.
REQ-032 Reset asserted mid-DISPENSE or mid-CHANGE SHALL abort the operation immediately with no refund; an outstanding disp_ack SHALL be ignored.

Configuration
REQ-033 With macro VEND_TIMEOUT_EN defined, DISPENSE SHALL count cycles without disp_ack.
- On reaching TIMEOUT_CYC, the block SHALL drop disp_req, pulse fault, add the latched price back to credit, and enter CHANGE.
REQ-034 With VEND_TIMEOUT_EN undefined, DISPENSE SHALL wait indefinitely, fault SHALL be tied to 0, and no counter logic SHALL exist.

Structure
REQ-035 Package vend_pkg SHALL hold:
- the state enum;
- the coin-code constants COIN_5 and COIN_10;
- the change-coin value 5;
- the default prices.
REQ-036 The timeout counter SHALL be sub-module vend_timeout_cnt, with ports clk, rst, en, clr and expired, instantiated only under VEND_TIMEOUT_EN.

Verification
REQ-037 The bench SHALL cover the directed scenarios below.
- Coins 10, 5 then sel 0 -> credit 15 -> 0, disp_req 1 cycle after sel with disp_id 0; ack -> IDLE, no chg_req.
- Coins 10, 10 then sel 3 -> dispense, then CHANGE; 2 chg_ack -> credit 0, IDLE.
- Credit 25, coin 10 -> coin_rej pulse, credit stays 25; sel 1 -> dispense, credit 5, one change coin.
- Credit 10, sel 2 -> sel_nack, IDLE; cancel -> 2 change handshakes, credit 0.
- Coin and sel in the same cycle with credit 10, coin 5, sel 0 -> credit 15, sel_nack, no dispense.
- VEND_TIMEOUT_EN with credit 20, sel 1, no ack for 16 cycles -> fault pulse, credit 20, 4 change coins; rst in CHANGE -> credit 0, IDLE next cycle.
